// File: rtl/hamming_class_search.sv
// hamming_class_search: buffers one query hypervector (NUM_FRAMES chunks),
// sweeps every (class, frame) address of the class-vector generator, sums
// the per-class Hamming distance and reports the minimum-distance class.
// Optional feature macro: HAMMING_SEARCH_ALL_DIST_EN adds a dist_all port
// exposing the final distance of every class.
module hamming_class_search #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int NUM_CLASSES        = 8,
  parameter int NUM_FRAMES         = 3,
  parameter int CLASS_ID_W         = 3,
  parameter int FRAME_IDX_W        = 2,
  parameter int DIST_W             = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          query_valid,
  output logic                          query_ready,
  input  logic [DI_PARALLEL_W_BITS-1:0] query_chunk,
  output logic [CLASS_ID_W-1:0]         frame_id,
  output logic [FRAME_IDX_W-1:0]        frame_index,
  input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [CLASS_ID_W-1:0]         result_class,
  output logic [DIST_W-1:0]             result_dist
`ifdef HAMMING_SEARCH_ALL_DIST_EN
  ,
  output logic [NUM_CLASSES*DIST_W-1:0] dist_all
`endif
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [FRAME_IDX_W-1:0] LAST_FRM = FRAME_IDX_W'(NUM_FRAMES - 1);
  localparam logic [CLASS_ID_W-1:0]  LAST_CLS = CLASS_ID_W'(NUM_CLASSES - 1);

  state_t                          state, state_nxt;
  logic [DI_PARALLEL_W_BITS-1:0]   query_buf [NUM_FRAMES];
  logic [FRAME_IDX_W-1:0]          load_cnt;
  logic [CLASS_ID_W-1:0]           cls;
  logic [FRAME_IDX_W-1:0]          frm;
  logic [DIST_W-1:0]               acc;
  logic [DIST_W-1:0]               best_dist;
  logic [CLASS_ID_W-1:0]           best_cls;
  logic [DIST_W-1:0]               pc;
  logic [DIST_W-1:0]               sum;
  logic                            sum_lt;
  logic                            last_frm;
  logic                            last_cls;
  logic                            load_last;

  // Number of set bits in a chunk, already at distance width.
  function automatic logic [DIST_W-1:0] popcount(input logic [DI_PARALLEL_W_BITS-1:0] v);
    logic [DIST_W-1:0] c;
    c = '0;
    for (int i = 0; i < DI_PARALLEL_W_BITS; i++) begin
      c = c + DIST_W'(v[i]);
    end
    return c;
  endfunction

  // Per-cycle distance contribution and running class sum.
  always_comb begin
    pc        = popcount(query_buf[frm] ^ class_vec_in);
    sum       = acc + pc;
    sum_lt    = (sum < best_dist);
    last_frm  = (frm == LAST_FRM);
    last_cls  = (cls == LAST_CLS);
    load_last = query_valid && (load_cnt == LAST_FRM);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt   = state;
    query_ready = 1'b0;
    case (state)
      LOAD: begin
        query_ready = 1'b1;
        if (load_last) state_nxt = SEARCH;
      end
      SEARCH: begin
        if (last_frm && last_cls) state_nxt = DONE;
      end
      DONE: begin
        if (result_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign frame_id    = cls;
  assign frame_index = frm;

  // Query buffering, address sweep, accumulation and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FRAMES; i++) query_buf[i] <= '0;
      load_cnt     <= '0;
      cls          <= '0;
      frm          <= '0;
      acc          <= '0;
      best_dist    <= '0;
      best_cls     <= '0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_dist  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (query_valid) begin
            query_buf[load_cnt] <= query_chunk;
            if (load_cnt == LAST_FRM) begin
              load_cnt  <= '0;
              cls       <= '0;
              frm       <= '0;
              acc       <= '0;
              best_dist <= '1;
              best_cls  <= '0;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        SEARCH: begin
          if (!last_frm) begin
            acc <= sum;
            frm <= frm + 1'b1;
          end else begin
            // Strict compare keeps the lowest class index on ties.
            if (sum_lt) begin
              best_dist <= sum;
              best_cls  <= cls;
            end
            acc <= '0;
            frm <= '0;
            if (last_cls) begin
              cls          <= '0;
              result_valid <= 1'b1;
              result_class <= sum_lt ? cls : best_cls;
              result_dist  <= sum_lt ? sum : best_dist;
            end else begin
              cls <= cls + 1'b1;
            end
          end
        end
        DONE: begin
          if (result_ready) result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef HAMMING_SEARCH_ALL_DIST_EN
  // Per-class final distances, cleared when a new sweep starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      dist_all <= '0;
    end else if (state == LOAD && load_last) begin
      dist_all <= '0;
    end else if (state == SEARCH && last_frm) begin
      dist_all[int'(cls)*DIST_W +: DIST_W] <= sum;
    end
  end
`endif

endmodule

// File: tb/tb_hamming_class_search.sv
// Directed self-checking bench for hamming_class_search with a behavioural
// class-vector source (stepped bit-mask, tie and hashed patterns).
module tb_hamming_class_search;

  localparam int W  = 64;
  localparam int NC = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          query_valid;
  logic          query_ready;
  logic [W-1:0]  query_chunk;
  logic [2:0]    frame_id;
  logic [1:0]    frame_index;
  logic [W-1:0]  class_vec_in;
  logic          result_valid;
  logic          result_ready;
  logic [2:0]    result_class;
  logic [DW-1:0] result_dist;
`ifdef HAMMING_SEARCH_ALL_DIST_EN
  logic [NC*DW-1:0] dist_all;
`endif

  int errors = 0;
  int checks = 0;
  logic [1:0] mode = 2'd0;

  always #5 clk = ~clk;

  hamming_class_search dut (
    .clk          (clk),
    .rst          (rst),
    .query_valid  (query_valid),
    .query_ready  (query_ready),
    .query_chunk  (query_chunk),
    .frame_id     (frame_id),
    .frame_index  (frame_index),
    .class_vec_in (class_vec_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_class (result_class),
    .result_dist  (result_dist)
`ifdef HAMMING_SEARCH_ALL_DIST_EN
    ,
    .dist_all     (dist_all)
`endif
  );

  // Class k: low 8k bits set, independent of frame.
  function automatic logic [W-1:0] model_m(input int k);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 8 * k; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Distinct per (class, frame) pattern standing in for class_hvec_gen.
  function automatic logic [W-1:0] model_h(input int c, input int f);
    logic [7:0] b;
    b = 8'(c * 37 + f * 11 + 5);
    return {8{b}};
  endfunction

  function automatic logic [W-1:0] gen(input logic [1:0] m, input logic [2:0] c, input logic [1:0] f);
    case (m)
      2'd0:    return model_m(int'(c));
      2'd1:    return 64'h00FF_00FF_00FF_00FF;
      default: return model_h(int'(c), int'(f));
    endcase
  endfunction

  assign class_vec_in = gen(mode, frame_id, frame_index);

  task automatic send_query(input logic [W-1:0] q0, input logic [W-1:0] q1,
                            input logic [W-1:0] q2, input int gap);
    logic [W-1:0] q [3];
    q[0] = q0; q[1] = q1; q[2] = q2;
    for (int f = 0; f < 3; f++) begin
      query_valid = 1'b1;
      query_chunk = q[f];
      @(posedge clk); #1;
      query_valid = 1'b0;
      if (f < 2) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!result_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_result;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    checks++; if (query_ready !== 1'b1) begin errors++; $display("FAIL reset_query_ready got %0b want 1", query_ready); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid got %0b want 0", result_valid); end
    checks++; if (result_class !== 3'd0) begin errors++; $display("FAIL reset_result_class got %0d want 0", result_class); end
    checks++; if (result_dist !== 8'd0) begin errors++; $display("FAIL reset_result_dist got %0d want 0", result_dist); end
    checks++; if (frame_id !== 3'd0) begin errors++; $display("FAIL reset_frame_id got %0d want 0", frame_id); end
    checks++; if (frame_index !== 2'd0) begin errors++; $display("FAIL reset_frame_index got %0d want 0", frame_index); end
  endtask

  task automatic test_query_zero;
    int n;
    mode = 2'd0;
    send_query('0, '0, '0, 0);
    checks++; if (query_ready !== 1'b0) begin errors++; $display("FAIL zero_search_query_ready got %0b want 0", query_ready); end
    wait_result(n);
    checks++; if (n !== 24) begin errors++; $display("FAIL zero_latency got %0d want 24", n); end
    checks++; if (result_class !== 3'd0) begin errors++; $display("FAIL zero_class got %0d want 0", result_class); end
    checks++; if (result_dist !== 8'd0) begin errors++; $display("FAIL zero_dist got %0d want 0", result_dist); end
`ifdef HAMMING_SEARCH_ALL_DIST_EN
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (dist_all[k*DW +: DW] !== 8'(24 * k)) begin
        errors++; $display("FAIL zero_dist_all[%0d] got %0d want %0d", k, dist_all[k*DW +: DW], 24 * k);
      end
    end
`endif
    release_result();
  endtask

  task automatic test_query_ones;
    int n;
    mode = 2'd0;
    send_query('1, '1, '1, 0);
    wait_result(n);
    checks++; if (n !== 24) begin errors++; $display("FAIL ones_latency got %0d want 24", n); end
    checks++; if (result_class !== 3'd7) begin errors++; $display("FAIL ones_class got %0d want 7", result_class); end
    checks++; if (result_dist !== 8'd24) begin errors++; $display("FAIL ones_dist got %0d want 24", result_dist); end
`ifdef HAMMING_SEARCH_ALL_DIST_EN
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (dist_all[k*DW +: DW] !== 8'(192 - 24 * k)) begin
        errors++; $display("FAIL ones_dist_all[%0d] got %0d want %0d", k, dist_all[k*DW +: DW], 192 - 24 * k);
      end
    end
`endif
    release_result();
  endtask

  task automatic test_tie;
    int n;
    mode = 2'd1;
    send_query('0, '0, '0, 0);
    wait_result(n);
    checks++; if (n !== 24) begin errors++; $display("FAIL tie_latency got %0d want 24", n); end
    checks++; if (result_class !== 3'd0) begin errors++; $display("FAIL tie_class got %0d want 0", result_class); end
    checks++; if (result_dist !== 8'd96) begin errors++; $display("FAIL tie_dist got %0d want 96", result_dist); end
  endtask

  // Runs directly after test_tie while its result is still pending.
  task automatic test_backpressure;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (result_valid !== 1'b1 || result_class !== 3'd0 || result_dist !== 8'd96 ||
          query_ready !== 1'b0 || frame_id !== 3'd0 || frame_index !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%0b c=%0d d=%0d qr=%0b fid=%0d fix=%0d want v=1 c=0 d=96 qr=0 fid=0 fix=0",
                 i, result_valid, result_class, result_dist, query_ready, frame_id, frame_index);
      end
    end
    release_result();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %0b want 0", result_valid); end
    checks++; if (query_ready !== 1'b1) begin errors++; $display("FAIL bp_release_query_ready got %0b want 1", query_ready); end
    checks++; if (result_dist !== 8'd96) begin errors++; $display("FAIL bp_release_dist_kept got %0d want 96", result_dist); end
  endtask

  task automatic test_reset_mid_search;
    int n;
    mode = 2'd0;
    send_query('1, '1, '1, 0);
    repeat (13) begin @(posedge clk); #1; end
    checks++;
    if (frame_id !== 3'd4 || frame_index !== 2'd1) begin
      errors++; $display("FAIL mid_addr got cls=%0d frm=%0d want cls=4 frm=1", frame_id, frame_index);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (query_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_query_ready got %0b want 1", query_ready); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_result_valid got %0b want 0", result_valid); end
    checks++; if (frame_id !== 3'd0) begin errors++; $display("FAIL mid_rst_frame_id got %0d want 0", frame_id); end
    repeat (30) begin
      @(posedge clk); #1;
      if (result_valid) break;
    end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_no_partial got %0b want 0", result_valid); end
    send_query('0, '0, '0, 0);
    wait_result(n);
    checks++; if (n !== 24) begin errors++; $display("FAIL mid_fresh_latency got %0d want 24", n); end
    checks++; if (result_class !== 3'd0) begin errors++; $display("FAIL mid_fresh_class got %0d want 0", result_class); end
    checks++; if (result_dist !== 8'd0) begin errors++; $display("FAIL mid_fresh_dist got %0d want 0", result_dist); end
    release_result();
  endtask

  task automatic test_class_match(input int gap);
    int n;
    mode = 2'd2;
    send_query(model_h(6, 0), model_h(6, 1), model_h(6, 2), gap);
    wait_result(n);
    checks++; if (n !== 24) begin errors++; $display("FAIL match_gap%0d_latency got %0d want 24", gap, n); end
    checks++; if (result_class !== 3'd6) begin errors++; $display("FAIL match_gap%0d_class got %0d want 6", gap, result_class); end
    checks++; if (result_dist !== 8'd0) begin errors++; $display("FAIL match_gap%0d_dist got %0d want 0", gap, result_dist); end
    release_result();
  endtask

  initial begin
    rst          = 1'b1;
    query_valid  = 1'b0;
    query_chunk  = '0;
    result_ready = 1'b0;
    test_reset();
    test_query_zero();
    test_query_ones();
    test_tie();
    test_backpressure();
    test_reset_mid_search();
    test_class_match(0);
    test_class_match(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
